// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: data memory port between the load/store controller and memory.
//   memReq   - request valid, held until memAck or timeout
//   memWe    - 1 = write, 0 = read
//   memAddr  - word-aligned byte address
//   memBe    - byte enables (bit n enables byte lane n)
//   memWdata - lane-placed write data
//   memRdata - read word, valid with memAck
//   memAck   - access complete
// Modports: master (controller side), slave (memory side).
interface lsu_ctrl_if;
   logic        memReq;
   logic        memWe;
   logic [31:0] memAddr;
   logic [3:0]  memBe;
   logic [31:0] memWdata;
   logic [31:0] memRdata;
   logic        memAck;

   modport master (
      output memReq, memWe, memAddr, memBe, memWdata,
      input  memRdata, memAck
   );

   modport slave (
      input  memReq, memWe, memAddr, memBe, memWdata,
      output memRdata, memAck
   );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between execute and the data memory port.
// Accepts one request in IDLE, checks control-code legality and alignment, issues a
// word-aligned memory access and waits for memAck (bounded by TIMEOUT cycles), then
// pulses respValid for one cycle. Loads hand the lane-shifted read word to the
// load-extension unit on extData/extCtrl.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   reqValid/reqWrite/reqCtrl/reqAddr/reqWdata - pipeline request
//   reqReady, stall     - pipeline handshake
//   respValid/respFault/faultCause - completion pulse and fault code
//   extCtrl, extData    - to the load-extension unit
//   mem                 - memory port (lsu_ctrl_if master)
module lsu_ctrl #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        reqValid,
   input  logic        reqWrite,
   input  logic [2:0]  reqCtrl,
   input  logic [31:0] reqAddr,
   input  logic [31:0] reqWdata,
   output logic        reqReady,
   output logic        stall,
   output logic        respValid,
   output logic        respFault,
   output logic [1:0]  faultCause,
   output logic [2:0]  extCtrl,
   output logic [31:0] extData,
   lsu_ctrl_if.master  mem
);

   localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

   typedef enum logic [1:0] {StIdle, StReq, StResp} state_t;

   state_t      state;
   logic [7:0]  waitCnt;
   logic [1:0]  addrLo;
   logic        isLoad;

   logic        illegal;
   logic        misaligned;
   logic [3:0]  beNext;
   logic [31:0] wdNext;

   // Request decode, only meaningful while reqValid in IDLE.
   always_comb begin
      illegal    = reqWrite ? (reqCtrl > 3'd2) : (reqCtrl > 3'd4);
      misaligned = 1'b0;
      beNext     = 4'b1111;
      wdNext     = 32'h0;
      case (reqCtrl)
         3'b001, 3'b100: misaligned = reqAddr[0];
         3'b010:         misaligned = (reqAddr[1:0] != 2'b00);
         default:        misaligned = 1'b0;
      endcase
      if (reqWrite) begin
         case (reqCtrl)
            3'b000: begin
               beNext = 4'b0001 << reqAddr[1:0];
               wdNext = {4{reqWdata[7:0]}};
            end
            3'b001: begin
               beNext = 4'b0011 << reqAddr[1:0];
               wdNext = {2{reqWdata[15:0]}};
            end
            default: begin
               beNext = 4'b1111;
               wdNext = reqWdata;
            end
         endcase
      end
   end

   assign reqReady = (state == StIdle);
   assign stall    = ((state == StIdle) && reqValid) || (state == StReq);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= StIdle;
         waitCnt      <= 8'd0;
         addrLo       <= 2'b00;
         isLoad       <= 1'b0;
         respValid    <= 1'b0;
         respFault    <= 1'b0;
         faultCause   <= 2'b00;
         extCtrl      <= 3'b010;
         extData      <= 32'h0;
         mem.memReq   <= 1'b0;
         mem.memWe    <= 1'b0;
         mem.memAddr  <= 32'h0;
         mem.memBe    <= 4'b0000;
         mem.memWdata <= 32'h0;
      end else begin
         respValid <= 1'b0;
         unique case (state)
            StIdle: begin
               if (reqValid) begin
                  addrLo  <= reqAddr[1:0];
                  isLoad  <= ~reqWrite;
                  waitCnt <= 8'd0;
                  extData <= 32'h0;
                  if (illegal || misaligned) begin
                     // Illegal code outranks misalignment.
                     state      <= StResp;
                     respValid  <= 1'b1;
                     respFault  <= 1'b1;
                     faultCause <= illegal ? 2'b11 : 2'b01;
                     extCtrl    <= 3'b010;
                  end else begin
                     state        <= StReq;
                     mem.memReq   <= 1'b1;
                     mem.memWe    <= reqWrite;
                     mem.memAddr  <= {reqAddr[31:2], 2'b00};
                     mem.memBe    <= beNext;
                     mem.memWdata <= wdNext;
                     extCtrl      <= reqWrite ? 3'b010 : reqCtrl;
                  end
               end
            end
            StReq: begin
               if (mem.memAck) begin
                  // Ack beats a timeout landing in the same cycle.
                  state      <= StResp;
                  respValid  <= 1'b1;
                  mem.memReq <= 1'b0;
                  mem.memWe  <= 1'b0;
                  mem.memBe  <= 4'b0000;
                  if (isLoad) extData <= mem.memRdata >> {addrLo, 3'b000};
               end else if ((waitCnt + 8'd1) == TimeoutCnt) begin
                  state      <= StResp;
                  respValid  <= 1'b1;
                  respFault  <= 1'b1;
                  faultCause <= 2'b10;
                  extCtrl    <= 3'b010;
                  mem.memReq <= 1'b0;
                  mem.memWe  <= 1'b0;
                  mem.memBe  <= 4'b0000;
               end else begin
                  waitCnt <= waitCnt + 8'd1;
               end
            end
            StResp: begin
               state      <= StIdle;
               respFault  <= 1'b0;
               faultCause <= 2'b00;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed self-checking bench for lsu_ctrl with TIMEOUT=4.
// Inputs change 1 time unit after the rising edge; outputs are checked at the same point.
module tb_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        reqValid;
   logic        reqWrite;
   logic [2:0]  reqCtrl;
   logic [31:0] reqAddr;
   logic [31:0] reqWdata;
   logic        reqReady;
   logic        stall;
   logic        respValid;
   logic        respFault;
   logic [1:0]  faultCause;
   logic [2:0]  extCtrl;
   logic [31:0] extData;

   int compared = 0;
   int mismatched = 0;

   lsu_ctrl_if memIf ();

   lsu_ctrl #(.TIMEOUT(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .reqValid   (reqValid),
      .reqWrite   (reqWrite),
      .reqCtrl    (reqCtrl),
      .reqAddr    (reqAddr),
      .reqWdata   (reqWdata),
      .reqReady   (reqReady),
      .stall      (stall),
      .respValid  (respValid),
      .respFault  (respFault),
      .faultCause (faultCause),
      .extCtrl    (extCtrl),
      .extData    (extData),
      .mem        (memIf)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present a request for one cycle; returns in cycle 1 of the transaction.
   task automatic issue(input logic wr, input logic [2:0] ctrl, input logic [31:0] addr,
                        input logic [31:0] wdata);
      reqValid = 1'b1;
      reqWrite = wr;
      reqCtrl  = ctrl;
      reqAddr  = addr;
      reqWdata = wdata;
      tick();
      reqValid = 1'b0;
      reqWrite = 1'b0;
      reqCtrl  = 3'b000;
      reqAddr  = 32'h0;
      reqWdata = 32'h0;
   endtask

   initial begin
      rst = 1'b1;
      reqValid = 1'b0; reqWrite = 1'b0; reqCtrl = 3'b000; reqAddr = 32'h0; reqWdata = 32'h0;
      memIf.memAck = 1'b0; memIf.memRdata = 32'h0;
      tick(); tick();

      // Reset state
      chk("rst reqReady", 32'(reqReady), 32'd1);
      chk("rst memReq", 32'(memIf.memReq), 32'd0);
      chk("rst respValid", 32'(respValid), 32'd0);
      chk("rst extCtrl", 32'(extCtrl), 32'd2);
      chk("rst extData", extData, 32'h0);
      chk("rst memBe", 32'(memIf.memBe), 32'd0);
      rst = 1'b0;
      tick();
      chk("idle stall", 32'(stall), 32'd0);

      // LW 0x100, zero-wait
      reqValid = 1'b1; #1;
      chk("accept stall", 32'(stall), 32'd1);
      issue(1'b0, 3'b010, 32'h100, 32'h0);
      chk("lw memReq", 32'(memIf.memReq), 32'd1);
      chk("lw memAddr", memIf.memAddr, 32'h100);
      chk("lw memBe", 32'(memIf.memBe), 32'hf);
      chk("lw memWe", 32'(memIf.memWe), 32'd0);
      chk("lw reqReady", 32'(reqReady), 32'd0);
      memIf.memAck = 1'b1; memIf.memRdata = 32'hDEADBEEF;
      tick();
      memIf.memAck = 1'b0; memIf.memRdata = 32'h0;
      chk("lw respValid", 32'(respValid), 32'd1);
      chk("lw respFault", 32'(respFault), 32'd0);
      chk("lw extData", extData, 32'hDEADBEEF);
      chk("lw extCtrl", 32'(extCtrl), 32'd2);
      chk("lw resp memReq", 32'(memIf.memReq), 32'd0);
      chk("lw resp stall", 32'(stall), 32'd0);
      tick();
      chk("lw one-pulse", 32'(respValid), 32'd0);
      chk("lw hold extData", extData, 32'hDEADBEEF);
      chk("lw idle ready", 32'(reqReady), 32'd1);

      // LB 0x103
      issue(1'b0, 3'b000, 32'h103, 32'h0);
      memIf.memAck = 1'b1; memIf.memRdata = 32'h80112233;
      tick();
      memIf.memAck = 1'b0;
      chk("lb respValid", 32'(respValid), 32'd1);
      chk("lb extData", extData, 32'h00000080);
      chk("lb extCtrl", 32'(extCtrl), 32'd0);
      tick();

      // LHU 0x102
      issue(1'b0, 3'b100, 32'h102, 32'h0);
      memIf.memAck = 1'b1; memIf.memRdata = 32'hABCD0000;
      tick();
      memIf.memAck = 1'b0; memIf.memRdata = 32'h0;
      chk("lhu extData", extData, 32'h0000ABCD);
      chk("lhu extCtrl", 32'(extCtrl), 32'd4);
      tick();

      // SB 0x201
      issue(1'b1, 3'b000, 32'h201, 32'h000000A5);
      chk("sb memWe", 32'(memIf.memWe), 32'd1);
      chk("sb memAddr", memIf.memAddr, 32'h200);
      chk("sb memBe", 32'(memIf.memBe), 32'b0010);
      chk("sb memWdata", memIf.memWdata, 32'hA5A5A5A5);
      memIf.memAck = 1'b1;
      tick();
      memIf.memAck = 1'b0;
      chk("sb respValid", 32'(respValid), 32'd1);
      chk("sb extData", extData, 32'h0);
      chk("sb extCtrl", 32'(extCtrl), 32'd2);
      tick();

      // SH 0x301: misaligned
      issue(1'b1, 3'b001, 32'h301, 32'h1234);
      chk("sh-mis memReq", 32'(memIf.memReq), 32'd0);
      chk("sh-mis respValid", 32'(respValid), 32'd1);
      chk("sh-mis respFault", 32'(respFault), 32'd1);
      chk("sh-mis cause", 32'(faultCause), 32'd1);
      tick();

      // Load code 111: illegal
      issue(1'b0, 3'b111, 32'h0, 32'h0);
      chk("ld-ill cause", 32'(faultCause), 32'd3);
      chk("ld-ill memReq", 32'(memIf.memReq), 32'd0);
      tick();

      // Store 011 misaligned: illegal
      issue(1'b1, 3'b011, 32'h3, 32'h0);
      chk("st011 cause", 32'(faultCause), 32'd3);
      tick();

      // Store 100 at odd address: illegal beats misaligned
      issue(1'b1, 3'b100, 32'h1, 32'h0);
      chk("st100 cause", 32'(faultCause), 32'd3);
      chk("st100 extCtrl", 32'(extCtrl), 32'd2);
      tick();

      // Timeout, no ack
      issue(1'b0, 3'b010, 32'h400, 32'h0);
      for (int c = 1; c <= 4; c++) begin
         chk($sformatf("to memReq c%0d", c), 32'(memIf.memReq), 32'd1);
         chk($sformatf("to respValid c%0d", c), 32'(respValid), 32'd0);
         tick();
      end
      chk("to respValid", 32'(respValid), 32'd1);
      chk("to respFault", 32'(respFault), 32'd1);
      chk("to cause", 32'(faultCause), 32'd2);
      chk("to memReq drop", 32'(memIf.memReq), 32'd0);
      chk("to extData", extData, 32'h0);
      tick();

      // Ack in cycle 4: no fault
      issue(1'b0, 3'b010, 32'h404, 32'h0);
      tick(); tick(); tick();
      chk("ack4 memReq", 32'(memIf.memReq), 32'd1);
      memIf.memAck = 1'b1; memIf.memRdata = 32'h12345678;
      tick();
      memIf.memAck = 1'b0; memIf.memRdata = 32'h0;
      chk("ack4 respValid", 32'(respValid), 32'd1);
      chk("ack4 respFault", 32'(respFault), 32'd0);
      chk("ack4 cause", 32'(faultCause), 32'd0);
      chk("ack4 extData", extData, 32'h12345678);
      tick();

      // Reset in the second REQ cycle
      issue(1'b0, 3'b010, 32'h500, 32'h0);
      tick();
      chk("rstmid memReq before", 32'(memIf.memReq), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rstmid memReq", 32'(memIf.memReq), 32'd0);
      chk("rstmid respValid", 32'(respValid), 32'd0);
      chk("rstmid reqReady", 32'(reqReady), 32'd1);
      tick();
      memIf.memAck = 1'b1; memIf.memRdata = 32'hFFFFFFFF;
      tick();
      memIf.memAck = 1'b0;
      chk("late ack respValid", 32'(respValid), 32'd0);
      chk("late ack memReq", 32'(memIf.memReq), 32'd0);
      chk("late ack reqReady", 32'(reqReady), 32'd1);
      chk("late ack extData", extData, 32'h0);
      tick();
      chk("late ack respValid2", 32'(respValid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
